// File: rtl/wb_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_unit_pkg
//  Description : Shared CPU-wide definitions used by the writeback unit:
//                datapath widths, writeback source select codes, load funct3
//                encodings and the mul/div FIFO entry type.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_unit_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    // Writeback source select (2'b11 is reserved and never writes)
    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;
    localparam logic [1:0] WB_SEL_RSVD = 2'b11;

    // Load funct3 encodings
    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

    // One buffered mul/div result
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } md_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_md_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_md_fifo
//  Description : DEPTH-entry synchronous FIFO of {rd, result} pairs for
//                out-of-order mul/div results. Transfers addressed to x0 are
//                handshaken but not stored.
//  Ports       : clk, rst_n           - clock, async active-low reset
//                push_valid/ready     - push handshake
//                push_entry           - {rd, result} to enqueue
//                pop                  - dequeue head (ignored when empty)
//                head                 - current head entry
//                count                - number of stored entries
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_md_fifo
    import wb_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_valid,
    output logic                   push_ready,
    input  md_entry_t              push_entry,
    input  logic                   pop,
    output md_entry_t              head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    md_entry_t          r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    // Ready comes from the registered count only, so a pop in the same
    // cycle never frees a slot for a push.
    assign push_ready = (r_count != CNT_W'(DEPTH));
    assign w_do_push  = push_valid && push_ready && (push_entry.rd != '0);
    assign w_do_pop   = pop && (r_count != '0);
    assign head       = r_mem[r_rd_ptr];
    assign count      = r_count;

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_entry;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_unit.sv
`default_nettype none
// ============================================================================
//  Module      : wb_unit
//  Description : RV32IM writeback unit. Arbitrates the register-file write
//                port between the in-order MEM/WB stream and buffered mul/div
//                results, extracts/extends load data and drops x0 writes.
//  Ports       : clk, rst_n                  - clock, async active-low reset
//                mem_*                       - MEM/WB pipeline entry
//                stall_o                     - MEM/WB entry held this cycle
//                md_valid/md_ready/md_rd/md_result - mul/div result push
//                we, waddr, wd               - registered write port
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_unit
    import wb_unit_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [1:0]            mem_wb_sel,
    input  logic [XLEN-1:0]       mem_alu_result,
    input  logic [XLEN-1:0]       mem_load_data,
    input  logic [2:0]            mem_funct3,
    input  logic [XLEN-1:0]       mem_pc4,
    output logic                  stall_o,
    input  logic                  md_valid,
    input  logic [REG_ADDR_W-1:0] md_rd,
    input  logic [XLEN-1:0]       md_result,
    output logic                  md_ready,
    output logic                  we,
    output logic [REG_ADDR_W-1:0] waddr,
    output logic [XLEN-1:0]       wd
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    md_entry_t               w_push_entry;
    md_entry_t               w_head;
    logic [$clog2(DEPTH):0]  w_fifo_count;
    logic                    w_fifo_empty;
    logic                    w_pw;
    logic                    w_starved;
    logic                    w_pop;
    logic                    w_pw_win;
    logic [XLEN-1:0]         w_pw_data;
    logic [STARVE_W-1:0]     r_starve_cnt;

    function automatic logic [XLEN-1:0] load_extract(
        input logic [2:0]      funct3,
        input logic [1:0]      offset,
        input logic [XLEN-1:0] word
    );
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] res;
        case (offset)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            LOAD_LB:  res = {{24{b[7]}}, b};
            LOAD_LBU: res = {24'd0, b};
            LOAD_LH:  res = {{16{h[15]}}, h};
            LOAD_LHU: res = {16'd0, h};
            LOAD_LW:  res = word;
            default:  res = '0;
        endcase
        return res;
    endfunction

    assign w_push_entry.rd   = md_rd;
    assign w_push_entry.data = md_result;

    wb_md_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (md_valid),
        .push_ready (md_ready),
        .push_entry (w_push_entry),
        .pop        (w_pop),
        .head       (w_head),
        .count      (w_fifo_count)
    );

    assign w_fifo_empty = (w_fifo_count == '0);
    assign w_pw         = mem_valid && (mem_wb_sel != WB_SEL_RSVD) && (mem_rd != '0);

    // The FIFO head wins when the pipeline has nothing to write or when it
    // has already lost STARVE_LIMIT consecutive arbitrations.
    assign w_starved = w_pw && (r_starve_cnt == STARVE_W'(STARVE_LIMIT));
    assign w_pop     = !w_fifo_empty && (!w_pw || w_starved);
    assign w_pw_win  = w_pw && !w_pop;
    assign stall_o   = w_pw && w_pop;

    always_comb begin
        w_pw_data = mem_alu_result;
        case (mem_wb_sel)
            WB_SEL_LOAD: w_pw_data = load_extract(mem_funct3, mem_alu_result[1:0], mem_load_data);
            WB_SEL_PC4:  w_pw_data = mem_pc4;
            default:     w_pw_data = mem_alu_result;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (w_fifo_empty || w_pop) begin
            r_starve_cnt <= '0;
        end else if (w_pw_win) begin
            r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
        end
    end

    // waddr/wd hold their last value when no write is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we    <= 1'b0;
            waddr <= '0;
            wd    <= '0;
        end else begin
            we <= w_pop || w_pw_win;
            if (w_pop) begin
                waddr <= w_head.rd;
                wd    <= w_head.data;
            end else if (w_pw_win) begin
                waddr <= mem_rd;
                wd    <= w_pw_data;
            end
        end
    end

endmodule
`default_nettype wire
